// File: rtl/vga_sink_if.sv
// Pixel-bus bundle between a VGA source and the vga_sink monitor:
// sync/data inputs towards the sink, capture and timing results back out.
interface vga_sink_if;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_de;
  logic [4:0]  vga_r;
  logic [5:0]  vga_g;
  logic [4:0]  vga_b;

  logic        cap_valid;
  logic [15:0] cap_x;
  logic [15:0] cap_y;
  logic [15:0] cap_rgb;
  logic        frame_done;
  logic [15:0] h_total;
  logic [15:0] v_total;
  logic [15:0] h_active;
  logic [15:0] v_active;
  logic [15:0] frame_sum;
  logic        locked;

  modport master (
    output vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b,
    input  cap_valid, cap_x, cap_y, cap_rgb, frame_done,
           h_total, v_total, h_active, v_active, frame_sum, locked
  );

  modport slave (
    input  vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b,
    output cap_valid, cap_x, cap_y, cap_rgb, frame_done,
           h_total, v_total, h_active, v_active, frame_sum, locked
  );
endinterface

// File: rtl/vga_sink.sv
// VGA receiver/monitor: recovers pixel coordinates, measures line/frame timing,
// sums pixels per frame and reports lock once consecutive frames agree.
module vga_sink #(
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic      pix_clk,
  input  logic      pix_rst,
  vga_sink_if.slave vga
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCK    = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
  localparam int H_TOT = 0;
  localparam int V_TOT = 1;
  localparam int H_ACT = 2;
  localparam int V_ACT = 3;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Input stage S1 and the one-cycle-later copy S2 used for edges and the capture pipe
  logic        hsync_s1_reg;
  logic        vsync_s1_reg;
  logic        de_s1_reg;
  logic [15:0] rgb_s1_reg;
  logic        hs_s2_reg;
  logic        vs_s2_reg;
  logic        de_s2_reg;
  logic [15:0] rgb_s2_reg;

  logic hs;
  logic vs;
  logic hs_edge;
  logic vs_edge;
  logic de_rise;
  logic de_fall;

  assign hs      = (hsync_s1_reg == HSYNC_POL);
  assign vs      = (vsync_s1_reg == VSYNC_POL);
  assign hs_edge = hs & ~hs_s2_reg;
  assign vs_edge = vs & ~vs_s2_reg;
  assign de_rise = de_s1_reg & ~de_s2_reg;
  assign de_fall = ~de_s1_reg & de_s2_reg;

  // Syncs reset to their inactive level so release never looks like an assertion edge
  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      hsync_s1_reg <= ~HSYNC_POL;
      vsync_s1_reg <= ~VSYNC_POL;
      de_s1_reg    <= 1'b0;
      rgb_s1_reg   <= 16'd0;
      hs_s2_reg    <= 1'b0;
      vs_s2_reg    <= 1'b0;
      de_s2_reg    <= 1'b0;
      rgb_s2_reg   <= 16'd0;
    end else begin
      hsync_s1_reg <= vga.vga_hsync;
      vsync_s1_reg <= vga.vga_vsync;
      de_s1_reg    <= vga.vga_de;
      rgb_s1_reg   <= {vga.vga_r, vga.vga_g, vga.vga_b};
      hs_s2_reg    <= hs;
      vs_s2_reg    <= vs;
      de_s2_reg    <= de_s1_reg;
      rgb_s2_reg   <= rgb_s1_reg;
    end
  end

  logic [15:0] h_cnt_reg, h_cnt_next;
  logic [15:0] line_len_reg, line_len_next;
  logic        line_err_reg, line_err_next, line_err_evt;
  logic [15:0] line_cnt_reg, line_cnt_next, line_cnt_evt;
  logic [15:0] x_cnt_reg, x_cnt_next;
  logic [15:0] y_cnt_reg, y_cnt_next, y_cnt_evt;
  logic [15:0] h_act_line_reg, h_act_line_next;
  logic [15:0] sum_reg, sum_next, sum_evt;
  logic [3:0][15:0] meas_reg;
  logic [3:0][15:0] meas_new;

  // Line and pixel events are folded in first (*_evt) so a coincident vs edge latches them
  always_comb begin
    h_cnt_next    = sat_inc(h_cnt_reg);
    line_len_next = line_len_reg;
    line_err_evt  = line_err_reg;
    line_cnt_evt  = line_cnt_reg;
    if (hs_edge) begin
      h_cnt_next    = 16'd1;
      line_len_next = h_cnt_reg;
      if ((line_cnt_reg != 16'd0) && (h_cnt_reg != line_len_reg)) begin
        line_err_evt = 1'b1;
      end
      line_cnt_evt = sat_inc(line_cnt_reg);
    end

    x_cnt_next = x_cnt_reg;
    if (de_rise) begin
      x_cnt_next = 16'd0;
    end else if (de_s1_reg) begin
      x_cnt_next = sat_inc(x_cnt_reg);
    end

    h_act_line_next = h_act_line_reg;
    y_cnt_evt       = y_cnt_reg;
    if (de_fall) begin
      h_act_line_next = sat_inc(x_cnt_reg);
      y_cnt_evt       = sat_inc(y_cnt_reg);
    end

    sum_evt = de_s1_reg ? (sum_reg + rgb_s1_reg) : sum_reg;

    meas_new[H_TOT] = line_len_next;
    meas_new[V_TOT] = line_cnt_evt;
    meas_new[H_ACT] = h_act_line_next;
    meas_new[V_ACT] = y_cnt_evt;

    line_cnt_next = line_cnt_evt;
    y_cnt_next    = y_cnt_evt;
    sum_next      = sum_evt;
    line_err_next = line_err_evt;
    if (vs_edge) begin
      line_cnt_next = 16'd0;
      y_cnt_next    = 16'd0;
      sum_next      = 16'd0;
      line_err_next = 1'b0;
    end
  end

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      h_cnt_reg      <= 16'd0;
      line_len_reg   <= 16'd0;
      line_err_reg   <= 1'b0;
      line_cnt_reg   <= 16'd0;
      x_cnt_reg      <= 16'd0;
      y_cnt_reg      <= 16'd0;
      h_act_line_reg <= 16'd0;
      sum_reg        <= 16'd0;
    end else begin
      h_cnt_reg      <= h_cnt_next;
      line_len_reg   <= line_len_next;
      line_err_reg   <= line_err_next;
      line_cnt_reg   <= line_cnt_next;
      x_cnt_reg      <= x_cnt_next;
      y_cnt_reg      <= y_cnt_next;
      h_act_line_reg <= h_act_line_next;
      sum_reg        <= sum_next;
    end
  end

  logic [3:0] field_eq;
  logic       has_prev_reg;
  logic       frame_good;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_cmp
    assign field_eq[gi] = (meas_new[gi] == meas_reg[gi]);
  end

  assign frame_good = has_prev_reg & ~line_err_evt & (&field_eq);

  state_t     state_reg, state_next;
  logic [3:0] good_cnt_reg, good_cnt_next;
  logic       update;

  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    update        = 1'b0;
    if (vs_edge) begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_ACQUIRE;
        end
        S_ACQUIRE: begin
          update = 1'b1;
          if (frame_good) begin
            good_cnt_next = good_cnt_reg + 4'd1;
            if (good_cnt_next >= LOCK_N) begin
              state_next = S_LOCK;
            end
          end else begin
            good_cnt_next = 4'd0;
          end
        end
        S_LOCK: begin
          update = 1'b1;
          if (!frame_good) begin
            state_next    = S_ACQUIRE;
            good_cnt_next = 4'd0;
          end
        end
        default: begin
          state_next    = S_IDLE;
          good_cnt_next = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      state_reg    <= S_IDLE;
      good_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
    end
  end

  logic [15:0] frame_sum_reg;
  logic        done_reg;

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      meas_reg      <= '0;
      frame_sum_reg <= 16'd0;
      has_prev_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= update;
      if (update) begin
        meas_reg      <= meas_new;
        frame_sum_reg <= sum_evt;
        has_prev_reg  <= 1'b1;
      end
    end
  end

  // Output stage: one more register so capture and frame results share a 2-cycle latency
  logic        cap_valid_reg;
  logic [15:0] cap_x_reg;
  logic [15:0] cap_y_reg;
  logic [15:0] cap_rgb_reg;
  logic        frame_done_reg;
  logic [3:0][15:0] meas_out_reg;
  logic [15:0] frame_sum_out_reg;
  logic        locked_reg;

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      cap_valid_reg     <= 1'b0;
      cap_x_reg         <= 16'd0;
      cap_y_reg         <= 16'd0;
      cap_rgb_reg       <= 16'd0;
      frame_done_reg    <= 1'b0;
      meas_out_reg      <= '0;
      frame_sum_out_reg <= 16'd0;
      locked_reg        <= 1'b0;
    end else begin
      cap_valid_reg     <= de_s2_reg;
      cap_x_reg         <= x_cnt_reg;
      cap_y_reg         <= y_cnt_reg;
      cap_rgb_reg       <= rgb_s2_reg;
      frame_done_reg    <= done_reg;
      meas_out_reg      <= meas_reg;
      frame_sum_out_reg <= frame_sum_reg;
      locked_reg        <= (state_reg == S_LOCK);
    end
  end

  assign vga.cap_valid  = cap_valid_reg;
  assign vga.cap_x      = cap_x_reg;
  assign vga.cap_y      = cap_y_reg;
  assign vga.cap_rgb    = cap_rgb_reg;
  assign vga.frame_done = frame_done_reg;
  assign vga.h_total    = meas_out_reg[H_TOT];
  assign vga.v_total    = meas_out_reg[V_TOT];
  assign vga.h_active   = meas_out_reg[H_ACT];
  assign vga.v_active   = meas_out_reg[V_ACT];
  assign vga.frame_sum  = frame_sum_out_reg;
  assign vga.locked     = locked_reg;

endmodule

// File: tb/tb_vga_sink.sv
// Directed bench for vga_sink: 28x12 timing with ramp / all-ones pixels, a line
// glitch in lock, an inverted-hsync instance, and asynchronous reset mid-line.
module tb_vga_sink;

  logic pix_clk = 1'b0;
  logic pix_rst;
  always #5 pix_clk = ~pix_clk;

  vga_sink_if bus ();
  vga_sink_if bus_p ();

  vga_sink #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOCK_FRAMES(2)) dut (
    .pix_clk(pix_clk), .pix_rst(pix_rst), .vga(bus)
  );
  vga_sink #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .LOCK_FRAMES(2)) dut_p (
    .pix_clk(pix_clk), .pix_rst(pix_rst), .vga(bus_p)
  );

  assign bus_p.vga_hsync = ~bus.vga_hsync;
  assign bus_p.vga_vsync = bus.vga_vsync;
  assign bus_p.vga_de    = bus.vga_de;
  assign bus_p.vga_r     = bus.vga_r;
  assign bus_p.vga_g     = bus.vga_g;
  assign bus_p.vga_b     = bus.vga_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge pix_clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] rgb;
  } pix_t;

  typedef struct {
    logic        locked;
    logic [15:0] ht;
    logic [15:0] vt;
    logic [15:0] ha;
    logic [15:0] va;
    logic [15:0] sum;
  } snap_t;

  typedef struct {
    int mode;        // 0: ramp x+16y, 1: every pixel 0xFFFF
    bit glitch;      // shorten active line 3 to 27 cycles
    bit exp_locked;
    int exp_ht;
    int exp_vt;
    int exp_ha;
    int exp_va;
    int exp_sum;
  } vec_t;

  pix_t  pq[$];
  snap_t snap[$];
  snap_t snap_p[$];
  vec_t  vec[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_snap(input string tag, input snap_t s, input vec_t v);
    chk({tag, "_locked"},    64'(s.locked), 64'(v.exp_locked));
    chk({tag, "_h_total"},   64'(s.ht),     64'(v.exp_ht));
    chk({tag, "_v_total"},   64'(s.vt),     64'(v.exp_vt));
    chk({tag, "_h_active"},  64'(s.ha),     64'(v.exp_ha));
    chk({tag, "_v_active"},  64'(s.va),     64'(v.exp_va));
    chk({tag, "_frame_sum"}, 64'(s.sum),    64'(v.exp_sum));
  endtask

  // Pixel scoreboard and frame_done snapshots, sampled mid-cycle
  logic prev_done   = 1'b0;
  logic prev_done_p = 1'b0;
  always @(negedge pix_clk) begin
    pix_t p;
    if (bus.cap_valid === 1'b1) begin
      if (pq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cap_unexpected actual=valid x=%0d y=%0d required=no capture", bus.cap_x, bus.cap_y);
      end else begin
        p = pq.pop_front();
        chk("cap_x_y_rgb_latency", {bus.cap_x, bus.cap_y, bus.cap_rgb, 16'(cyc - p.stamp)},
            {p.x, p.y, p.rgb, 16'd2});
      end
    end
    if (bus.frame_done === 1'b1) begin
      chk("done_width", 64'(prev_done), 64'd0);
      snap.push_back('{locked: bus.locked, ht: bus.h_total, vt: bus.v_total,
                       ha: bus.h_active, va: bus.v_active, sum: bus.frame_sum});
      $display("frame_done dut   locked=%0d h_total=%0d v_total=%0d h_active=%0d v_active=%0d frame_sum=%0h",
               bus.locked, bus.h_total, bus.v_total, bus.h_active, bus.v_active, bus.frame_sum);
    end
    if (bus_p.frame_done === 1'b1) begin
      chk("done_width_pol", 64'(prev_done_p), 64'd0);
      snap_p.push_back('{locked: bus_p.locked, ht: bus_p.h_total, vt: bus_p.v_total,
                         ha: bus_p.h_active, va: bus_p.v_active, sum: bus_p.frame_sum});
      $display("frame_done dut_p locked=%0d h_total=%0d v_total=%0d h_active=%0d v_active=%0d frame_sum=%0h",
               bus_p.locked, bus_p.h_total, bus_p.v_total, bus_p.h_active, bus_p.v_active, bus_p.frame_sum);
    end
    prev_done   = bus.frame_done;
    prev_done_p = bus_p.frame_done;
  end

  task automatic drive(input logic hs_n, input logic vs_n, input logic de,
                       input logic [15:0] rgb, input logic [15:0] x, input logic [15:0] y);
    @(posedge pix_clk);
    #1;
    bus.vga_hsync = hs_n;
    bus.vga_vsync = vs_n;
    bus.vga_de    = de;
    {bus.vga_r, bus.vga_g, bus.vga_b} = rgb;
    if (de) pq.push_back('{stamp: cyc + 1, x: x, y: y, rgb: rgb});
  endtask

  // Frame starts at the vsync assertion: 2 sync lines, 1 back porch, 8 active, 1 front porch
  task automatic gen_frame(input int mode, input bit glitch);
    for (int l = 0; l < 12; l++) begin
      logic vs_n;
      bit   act;
      int   y;
      int   len;
      vs_n = (l < 2) ? 1'b0 : 1'b1;
      act  = (l >= 3) && (l <= 10);
      y    = l - 3;
      len  = (glitch && act && (y == 3)) ? 27 : 28;
      for (int c = 0; c < len; c++) begin
        int          cc;
        bit          de;
        logic        hs_n;
        logic [15:0] px;
        cc   = ((len == 27) && (c >= 16)) ? c + 1 : c;
        de   = act && (cc < 16);
        hs_n = ((cc >= 20) && (cc < 24)) ? 1'b0 : 1'b1;
        px   = 16'd0;
        if (de) px = (mode == 1) ? 16'hFFFF : 16'(cc + y * 16);
        drive(hs_n, vs_n, de, px, 16'(cc), 16'(y));
      end
    end
  endtask

  initial begin
    vec[0] = '{0, 1'b0, 1'b0, 28, 12, 16, 8, 8128};
    vec[1] = '{0, 1'b0, 1'b0, 28, 12, 16, 8, 8128};
    vec[2] = '{0, 1'b0, 1'b1, 28, 12, 16, 8, 8128};
    vec[3] = '{1, 1'b0, 1'b1, 28, 12, 16, 8, 16'hFF80};
    vec[4] = '{0, 1'b1, 1'b0, 28, 12, 16, 8, 8128};
    vec[5] = '{0, 1'b0, 1'b0, 28, 12, 16, 8, 8128};
    vec[6] = '{0, 1'b0, 1'b1, 28, 12, 16, 8, 8128};

    pix_rst       = 1'b1;
    bus.vga_hsync = 1'b1;
    bus.vga_vsync = 1'b1;
    bus.vga_de    = 1'b0;
    {bus.vga_r, bus.vga_g, bus.vga_b} = 16'd0;

    repeat (3) @(negedge pix_clk);
    chk("rst_cap", {bus.cap_valid, bus.cap_x, bus.cap_y, bus.cap_rgb}, 64'd0);
    chk("rst_flags", {bus.frame_done, bus.locked, bus_p.locked}, 64'd0);
    chk("rst_meas", {bus.h_total, bus.v_total, bus.h_active, bus.v_active}, 64'd0);
    chk("rst_sum", 64'(bus.frame_sum), 64'd0);

    @(posedge pix_clk);
    #1;
    pix_rst = 1'b0;
    repeat (5) drive(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0);

    for (int i = 0; i < 7; i++) gen_frame(vec[i].mode, vec[i].glitch);
    gen_frame(0, 1'b0);

    chk("frame_count", 64'(snap.size()), 64'd7);
    chk("frame_count_pol", 64'(snap_p.size()), 64'd7);
    for (int i = 0; i < snap.size() && i < 7; i++) check_snap($sformatf("f%0d", i), snap[i], vec[i]);
    for (int i = 0; i < snap_p.size() && i < 7; i++) check_snap($sformatf("pol_f%0d", i), snap_p[i], vec[i]);

    // Reset in the middle of an active run while locked
    for (int c = 0; c < 8; c++) drive(1'b1, 1'b1, 1'b1, 16'(c), 16'(c), 16'd8);
    #1;
    pix_rst = 1'b1;
    pq.delete();
    #1;
    chk("async_rst_cap", {bus.cap_valid, bus.cap_x, bus.cap_y, bus.cap_rgb}, 64'd0);
    chk("async_rst_flags", {bus.frame_done, bus.locked, bus_p.locked}, 64'd0);
    chk("async_rst_meas", {bus.h_total, bus.v_total, bus.h_active, bus.v_active}, 64'd0);
    chk("async_rst_sum", 64'(bus.frame_sum), 64'd0);
    bus.vga_de = 1'b0;
    {bus.vga_r, bus.vga_g, bus.vga_b} = 16'd0;
    repeat (3) @(posedge pix_clk);
    #1;
    snap.delete();
    snap_p.delete();
    pix_rst = 1'b0;
    repeat (4) drive(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0);

    gen_frame(0, 1'b0);
    chk("no_done_first_vsync", 64'(snap.size()), 64'd0);
    chk("no_done_first_vsync_pol", 64'(snap_p.size()), 64'd0);
    gen_frame(0, 1'b0);
    chk("done_second_vsync", 64'(snap.size()), 64'd1);
    if (snap.size() > 0) check_snap("after_rst", snap[0], vec[0]);
    chk("pixels_drained", 64'(pq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sink.md
# vga_sink

Pixel-domain VGA receiver/monitor for the far end of the display interface driven by the top-level output flops. It samples hsync, vsync, de and 5/6/5 RGB on the pixel clock and recovers per-pixel coordinates. It measures line and frame timing, computes a per-frame pixel checksum and reports lock once timing is stable. It serves as a self-check block in simulation and as a loopback monitor on FPGA.

## Interface

Parameters:
- HSYNC_POL, default 0: active level of vga_hsync (0 = active-low).
- VSYNC_POL, default 0: active level of vga_vsync.
- LOCK_FRAMES, default 2: consecutive consistent frames required to enter LOCK (1..15).

Ports:
- pix_clk  in  1  pixel clock.
- pix_rst  in  1  asynchronous, active-high reset.
- vga_hsync  in  1  horizontal sync.
- vga_vsync  in  1  vertical sync.
- vga_de  in  1  data enable.
- vga_r  in  5  red.
- vga_g  in  6  green.
- vga_b  in  5  blue.
- cap_valid  out  1  captured pixel valid.
- cap_x  out  16  active pixel index within the line.
- cap_y  out  16  active line index within the frame.
- cap_rgb  out  16  captured pixel {r,g,b}.
- frame_done  out  1  one-cycle pulse: measurements updated.
- h_total  out  16  pix_clk cycles per line.
- v_total  out  16  lines per frame.
- h_active  out  16  de cycles in the last active line.
- v_active  out  16  active lines in the last frame.
- frame_sum  out  16  modulo-2^16 sum of cap_rgb over the last frame.
- locked  out  1  timing stable.

## Operation

- All inputs are registered once (stage S1). Normalized hs = (S1 hsync == HSYNC_POL) and vs = (S1 vsync == VSYNC_POL). Edge detection compares S1 against a second register.
- **Line timing:** h_cnt resets to 1 on each hs assertion edge, otherwise increments, saturating at 0xFFFF.
  - At each hs assertion edge, line_len is set to h_cnt (the previous count).
  - If line_len differs from the preceding line_len within the same frame, the sticky line_err flag is set.
- **Active pixels:** x_cnt resets to 0 on the de rising edge and increments per de cycle.
  - On the de falling edge, h_act_line is set to x_cnt+1 and y_cnt increments.
  - de high on consecutive cycles counts as one run.
- **Frame timing:** line_cnt counts hs assertion edges since the last vs assertion edge.
  - At each vs assertion edge: v_total←line_cnt, v_active←y_cnt, h_total←line_len, h_active←h_act_line, frame_sum←running sum.
  - At the same edge, y_cnt, line_cnt, the running sum and line_err are cleared.
- **Checksum:** for every de cycle, the running sum becomes sum + {r,g,b}, truncated to 16 bits.
- **FSM:**
  - IDLE: from reset. The first vs edge moves to ACQUIRE and updates no outputs, because the frame was partial.
  - ACQUIRE: at each vs edge, the frame is good if line_err=0 and the new {h_total, v_total, h_active, v_active} equal the previous values. Good frames increment good_cnt; bad frames reset it to 0. good_cnt reaching LOCK_FRAMES moves to LOCK.
  - LOCK: locked=1. Any bad frame at a vs edge moves to ACQUIRE with good_cnt=0 and locked=0 in the same cycle the outputs update.
  - The first measured frame has no predecessor, so it is never good.
- **Simultaneous events:** if hs and vs assert in the same cycle, the hs edge is processed first. The line count therefore includes that line, and line_cnt restarts at 0 after the latch. The line_err comparison is skipped on the first line of a frame.

## Timing

- Reset values:
  - cap_valid=0, cap_x=0, cap_y=0, cap_rgb=0, frame_done=0, locked=0.
  - All measurement outputs 0. FSM=IDLE, all counters 0.
- Capture latency: input sampled at edge N; cap_valid, cap_x, cap_y and cap_rgb appear registered after edge N+2. cap_valid is high for exactly the number of de cycles.
- frame_done pulses for one cycle, 2 cycles after the vs-asserted input sample. Measurement outputs and locked change in that same cycle and hold until the next pulse. frame_done never pulses in IDLE.
- Counter saturation: none of h_cnt, x_cnt, y_cnt or line_cnt wraps; each saturates at 0xFFFF.
- Reset asserted mid-frame takes effect immediately (asynchronous). After deassertion the block restarts in IDLE and ignores the first, partial frame.

## Test plan

- **Nominal timing.** Line of 16 active, 4 front porch, 4 sync, 4 back porch (28 cycles); frame of 8 active, 1 front porch, 2 sync, 1 back porch (12 lines), with HSYNC_POL=VSYNC_POL=0. Expected:
  - h_total=28, v_total=12, h_active=16, v_active=8.
  - locked rises at the frame_done of the 3rd full frame after the first vsync.
- **Capture ramp.** Pixel value {r,g,b} = cap_x + cap_y·16. Expected:
  - cap_x sweeps 0..15 and cap_y sweeps 0..7.
  - frame_sum = 8128 (sum 0..127).
  - Each cap output lags its input by 2 cycles.
- **Line glitch in LOCK.** One line shortened to 27 cycles. Expected: at the next frame_done, locked=0 and the FSM is in ACQUIRE; locked=1 again 2 good frames later.
- **Polarity.** HSYNC_POL=1 with inverted sync stimulus. Expected: measurements identical to the nominal-timing scenario.
- **Reset mid-frame.** Assert pix_rst mid-line. Expected: all outputs are 0 immediately; no frame_done until the second vsync after release.
- **Checksum wrap.** Every pixel 0xFFFF, 16×8 frame. Expected: frame_sum = (128·0xFFFF) mod 2^16 = 0xFF80.
